// File: rtl/new_means_calc_pkg.sv
// Shared constants, FSM state type and quotient saturation helper for the
// k-means centroid update block.
package new_means_calc_pkg;

  localparam int NUM_CENT  = 8;
  localparam int NUM_COORD = 7;
  localparam int COORD_W   = 13;
  localparam int ACC_W     = 22;
  localparam int CNT_W     = 10;
  localparam int IDX_W     = 3;
  localparam int ITER_W    = 5;
  localparam int DATA_W    = NUM_COORD * COORD_W;
  localparam int ACCUM_W   = NUM_COORD * ACC_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DIV   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Any quotient bit above the coordinate width means the value exceeds 8191.
  function automatic logic [COORD_W-1:0] sat_quot(input logic [ACC_W-1:0] q);
    if (|q[ACC_W-1:COORD_W]) return '1;
    return q[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/new_means_calc_seq_divider.sv
// Unsigned restoring divider, 22-bit dividend by 10-bit divisor, one quotient
// bit per cycle MSB first, with a 13-bit saturated quotient.
module seq_divider
  import new_means_calc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [ACC_W-1:0]   dividend,
  input  logic [CNT_W-1:0]   divisor,
  output logic               busy,
  output logic               last,
  output logic [COORD_W-1:0] quotient
);

  logic [ACC_W-1:0]  dvd_q, dvd_d;
  logic [CNT_W-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [CNT_W:0]    trial;

  // Quotient bits are shifted into the vacated LSBs of the dividend register.
  always_comb begin
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    iter_d = iter_q;
    trial  = {rem_q, dvd_q[ACC_W-1]};
    if (load) begin
      dvd_d  = dividend;
      dvs_d  = divisor;
      rem_d  = '0;
      iter_d = ITER_W'(ACC_W);
    end else if (iter_q != '0) begin
      iter_d = iter_q - ITER_W'(1);
      if (trial >= {1'b0, dvs_q}) begin
        rem_d = trial[CNT_W-1:0] - dvs_q;
        dvd_d = {dvd_q[ACC_W-2:0], 1'b1};
      end else begin
        rem_d = trial[CNT_W-1:0];
        dvd_d = {dvd_q[ACC_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      iter_q <= '0;
    end else begin
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      iter_q <= iter_d;
    end
  end

  assign busy = (iter_q != '0);
  // Final iteration this cycle; quotient is the value being registered now.
  assign last     = (iter_q == ITER_W'(1));
  assign quotient = sat_quot(dvd_d);

endmodule

// File: rtl/new_means_calc.sv
// K-means centroid update: divides each of the eight per-centroid sums by its
// point count and writes the eight new centroids out one strobe at a time.
module new_means_calc
  import new_means_calc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ACCUM_W-1:0] accum_1,
  input  logic [ACCUM_W-1:0] accum_2,
  input  logic [ACCUM_W-1:0] accum_3,
  input  logic [ACCUM_W-1:0] accum_4,
  input  logic [ACCUM_W-1:0] accum_5,
  input  logic [ACCUM_W-1:0] accum_6,
  input  logic [ACCUM_W-1:0] accum_7,
  input  logic [ACCUM_W-1:0] accum_8,
  input  logic [CNT_W-1:0]   cnt_1,
  input  logic [CNT_W-1:0]   cnt_2,
  input  logic [CNT_W-1:0]   cnt_3,
  input  logic [CNT_W-1:0]   cnt_4,
  input  logic [CNT_W-1:0]   cnt_5,
  input  logic [CNT_W-1:0]   cnt_6,
  input  logic [CNT_W-1:0]   cnt_7,
  input  logic [CNT_W-1:0]   cnt_8,
  input  logic [DATA_W-1:0]  centroid_reg_1,
  input  logic [DATA_W-1:0]  centroid_reg_2,
  input  logic [DATA_W-1:0]  centroid_reg_3,
  input  logic [DATA_W-1:0]  centroid_reg_4,
  input  logic [DATA_W-1:0]  centroid_reg_5,
  input  logic [DATA_W-1:0]  centroid_reg_6,
  input  logic [DATA_W-1:0]  centroid_reg_7,
  input  logic [DATA_W-1:0]  centroid_reg_8,
  output logic               busy,
  output logic               new_centroid_valid,
  output logic [IDX_W-1:0]   cent_cnt,
  output logic [DATA_W-1:0]  new_centroid,
  output logic               done,
  output logic [2:0]         dbg_state
);

  logic [ACCUM_W-1:0] accum_a [NUM_CENT];
  logic [CNT_W-1:0]   cnt_a   [NUM_CENT];
  logic [DATA_W-1:0]  creg_a  [NUM_CENT];

  assign accum_a = '{accum_1, accum_2, accum_3, accum_4,
                     accum_5, accum_6, accum_7, accum_8};
  assign cnt_a   = '{cnt_1, cnt_2, cnt_3, cnt_4, cnt_5, cnt_6, cnt_7, cnt_8};
  assign creg_a  = '{centroid_reg_1, centroid_reg_2, centroid_reg_3,
                     centroid_reg_4, centroid_reg_5, centroid_reg_6,
                     centroid_reg_7, centroid_reg_8};

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [IDX_W-1:0]   cent_cnt_q, cent_cnt_d;
  logic [DATA_W-1:0]  new_cent_q, new_cent_d;

  logic [ACCUM_W-1:0] sel_accum;
  logic [CNT_W-1:0]   sel_cnt;
  logic [DATA_W-1:0]  sel_creg;
  logic               div_load;
  logic [NUM_COORD-1:0] div_busy, div_last;
  logic [DATA_W-1:0]  div_packed;
  logic               div_fin;

  assign sel_accum = accum_a[idx_q];
  assign sel_cnt   = cnt_a[idx_q];
  assign sel_creg  = creg_a[idx_q];

  for (genvar k = 0; k < NUM_COORD; k++) begin : g_div
    seq_divider u_div (
      .clk      (clk),
      .rst      (rst),
      .load     (div_load),
      .dividend (sel_accum[k*ACC_W +: ACC_W]),
      .divisor  (sel_cnt),
      .busy     (div_busy[k]),
      .last     (div_last[k]),
      .quotient (div_packed[k*COORD_W +: COORD_W])
    );
  end

  // All seven dividers are loaded together and finish on the same cycle.
  assign div_fin = (&div_last) & (&div_busy);

  // new_centroid_valid is a one-cycle write strobe with no back-pressure;
  // cent_cnt/new_centroid are meaningful only while it is high.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    cent_cnt_d = cent_cnt_q;
    new_cent_d = new_cent_q;
    div_load   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        if (sel_cnt == '0) begin
          state_d    = S_WRITE;
          valid_d    = 1'b1;
          cent_cnt_d = idx_q;
          new_cent_d = sel_creg;
        end else begin
          div_load = 1'b1;
          state_d  = S_DIV;
        end
      end
      S_DIV: begin
        if (div_fin) begin
          state_d    = S_WRITE;
          valid_d    = 1'b1;
          cent_cnt_d = idx_q;
          new_cent_d = div_packed;
        end
      end
      S_WRITE: begin
        if (idx_q == IDX_W'(NUM_CENT - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      cent_cnt_q <= '0;
      new_cent_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      cent_cnt_q <= cent_cnt_d;
      new_cent_q <= new_cent_d;
    end
  end

  assign busy               = busy_q;
  assign new_centroid_valid = valid_q;
  assign done               = done_q;
  assign cent_cnt           = cent_cnt_q;
  assign new_centroid       = new_cent_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_new_means_calc.sv
// Directed bench for new_means_calc: cycle-accurate strobe/done timing,
// division, empty-cluster, saturation, start filtering and reset behaviour.
module tb_new_means_calc;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [153:0] accum_tb [8];
  logic [9:0]   cnt_tb   [8];
  logic [90:0]  creg_tb  [8];
  logic         busy, new_centroid_valid, done;
  logic [2:0]   cent_cnt;
  logic [90:0]  new_centroid;
  logic [2:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  int          st_cyc [$];
  logic [2:0]  st_idx [$];
  logic [90:0] st_dat [$];
  int          done_cyc [$];
  int          busy_fall;
  int          overlap;
  logic [96:0] snap;

  always #5 clk = ~clk;

  new_means_calc dut (
    .clk(clk), .rst(rst), .start(start),
    .accum_1(accum_tb[0]), .accum_2(accum_tb[1]), .accum_3(accum_tb[2]),
    .accum_4(accum_tb[3]), .accum_5(accum_tb[4]), .accum_6(accum_tb[5]),
    .accum_7(accum_tb[6]), .accum_8(accum_tb[7]),
    .cnt_1(cnt_tb[0]), .cnt_2(cnt_tb[1]), .cnt_3(cnt_tb[2]), .cnt_4(cnt_tb[3]),
    .cnt_5(cnt_tb[4]), .cnt_6(cnt_tb[5]), .cnt_7(cnt_tb[6]), .cnt_8(cnt_tb[7]),
    .centroid_reg_1(creg_tb[0]), .centroid_reg_2(creg_tb[1]),
    .centroid_reg_3(creg_tb[2]), .centroid_reg_4(creg_tb[3]),
    .centroid_reg_5(creg_tb[4]), .centroid_reg_6(creg_tb[5]),
    .centroid_reg_7(creg_tb[6]), .centroid_reg_8(creg_tb[7]),
    .busy(busy), .new_centroid_valid(new_centroid_valid), .cent_cnt(cent_cnt),
    .new_centroid(new_centroid), .done(done), .dbg_state(dbg_state)
  );

  task automatic fill(input int c, input logic [21:0] s, input logic [9:0] n,
                      input logic [12:0] r);
    for (int k = 0; k < 7; k++) begin
      accum_tb[c][k*22 +: 22] = s;
      creg_tb[c][k*13 +: 13]  = r;
    end
    cnt_tb[c] = n;
  endtask

  task automatic load_base();
    fill(0, 22'd1000, 10'd3, 13'd5);
    fill(1, 22'd44, 10'd4, 13'd5);
    fill(2, 22'd700, 10'd7, 13'd5);
    fill(3, 22'd0, 10'd10, 13'd5);
    for (int k = 0; k < 7; k++) accum_tb[3][k*22 +: 22] = 22'(1000 * k + 7);
    fill(4, 22'd5000, 10'd1, 13'd5);
    fill(5, 22'd9, 10'd10, 13'd5);
    fill(6, 22'd4000000, 10'd500, 13'd5);
    fill(7, 22'd12345, 10'd1000, 13'd5);
  endtask

  function automatic logic [90:0] exp_cent(input int c);
    logic [90:0] r;
    int unsigned s, q;
    r = '0;
    for (int k = 0; k < 7; k++) begin
      s = 32'(accum_tb[c][k*22 +: 22]);
      if (cnt_tb[c] == 10'd0) begin
        r[k*13 +: 13] = creg_tb[c][k*13 +: 13];
      end else begin
        q = s / 32'(cnt_tb[c]);
        if (q > 8191) q = 8191;
        r[k*13 +: 13] = 13'(q);
      end
    end
    return r;
  endfunction

  // Cycle c is the rising edge at which the sampled values are seen; the
  // start edge is cycle 0. Inputs set in iteration c are sampled at edge c.
  task automatic run_capture(input int n, input int p1, input int p2,
                             input int p3, input int rst_c);
    st_cyc.delete(); st_idx.delete(); st_dat.delete(); done_cyc.delete();
    busy_fall = -1;
    overlap   = 0;
    snap      = '1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (new_centroid_valid) begin
        st_cyc.push_back(c);
        st_idx.push_back(cent_cnt);
        st_dat.push_back(new_centroid);
      end
      if (done) done_cyc.push_back(c);
      if (new_centroid_valid && done) overlap++;
      if (!busy && busy_fall < 0) busy_fall = c;
      if (c == rst_c + 1)
        snap = {busy, new_centroid_valid, done, cent_cnt, new_centroid};
      start = (c == p1 || c == p2 || c == p3);
      rst   = (c == rst_c);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      accum_tb[c] = '0;
      cnt_tb[c]   = '0;
      creg_tb[c]  = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, new_centroid_valid, done, cent_cnt, new_centroid} !== 97'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%0b v=%0b d=%0b cnt=%0d cent=%h want all 0",
               busy, new_centroid_valid, done, cent_cnt, new_centroid);
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got %0d want 0", dbg_state);
    end
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      checks++;
      if (dbg_state !== 3'd0 || busy !== 1'b0 || new_centroid_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold cyc %0d got state=%0d busy=%0b v=%0b want 0/0/0",
                 c, dbg_state, busy, new_centroid_valid);
      end
    end
  endtask

  task automatic test_exact_division();
    int t;
    int dc;
    logic [90:0] d;
    load_base();
    run_capture(230, -1, -1, -1, -1);
    checks++;
    if (st_cyc.size() != 8) begin
      errors++;
      $display("FAIL exact_strobe_count got %0d want 8", st_cyc.size());
    end
    t = 0;
    for (int i = 0; i < 8 && i < st_cyc.size(); i++) begin
      t += (cnt_tb[i] == 10'd0) ? 2 : 24;
      checks++;
      if (st_cyc[i] != t || st_idx[i] !== 3'(i)) begin
        errors++;
        $display("FAIL exact_strobe_%0d got cyc=%0d idx=%0d want cyc=%0d idx=%0d",
                 i, st_cyc[i], st_idx[i], t, i);
      end
      checks++;
      if (st_dat[i] !== exp_cent(i)) begin
        errors++;
        $display("FAIL exact_data_%0d got %h want %h", i, st_dat[i], exp_cent(i));
      end
    end
    if (st_dat.size() >= 4) begin
      for (int k = 0; k < 7; k++) begin
        d = st_dat[0];
        checks++;
        if (d[k*13 +: 13] !== 13'd333) begin
          errors++;
          $display("FAIL exact_c0_coord%0d got %0d want 333", k, d[k*13 +: 13]);
        end
        d = st_dat[1];
        checks++;
        if (d[k*13 +: 13] !== 13'd11) begin
          errors++;
          $display("FAIL exact_c1_coord%0d got %0d want 11", k, d[k*13 +: 13]);
        end
        d = st_dat[3];
        checks++;
        if (d[k*13 +: 13] !== 13'(100 * k)) begin
          errors++;
          $display("FAIL trunc_c3_coord%0d got %0d want %0d", k, d[k*13 +: 13], 100 * k);
        end
      end
    end
    dc = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    checks++;
    if (done_cyc.size() != 1 || dc != 193) begin
      errors++;
      $display("FAIL exact_done got n=%0d cyc=%0d want n=1 cyc=193", done_cyc.size(), dc);
    end
    checks++;
    if (busy_fall != 194) begin
      errors++;
      $display("FAIL exact_busy_fall got %0d want 194", busy_fall);
    end
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL exact_valid_done_overlap got %0d want 0", overlap);
    end
    settle();
  endtask

  task automatic test_empty_cluster();
    int t;
    int dc;
    logic [90:0] d;
    load_base();
    fill(2, 22'd700, 10'd0, 13'd77);
    run_capture(230, -1, -1, -1, -1);
    checks++;
    if (st_cyc.size() != 8) begin
      errors++;
      $display("FAIL empty_strobe_count got %0d want 8", st_cyc.size());
    end
    t = 0;
    for (int i = 0; i < 8 && i < st_cyc.size(); i++) begin
      t += (cnt_tb[i] == 10'd0) ? 2 : 24;
      checks++;
      if (st_cyc[i] != t || st_idx[i] !== 3'(i) || st_dat[i] !== exp_cent(i)) begin
        errors++;
        $display("FAIL empty_strobe_%0d got cyc=%0d idx=%0d dat=%h want cyc=%0d idx=%0d dat=%h",
                 i, st_cyc[i], st_idx[i], st_dat[i], t, i, exp_cent(i));
      end
    end
    if (st_dat.size() >= 3) begin
      d = st_dat[2];
      checks++;
      if (st_cyc[2] != 50 || d[6*13 +: 13] !== 13'd77 || d[0 +: 13] !== 13'd77) begin
        errors++;
        $display("FAIL empty_c2 got cyc=%0d c0=%0d c6=%0d want cyc=50 77 77",
                 st_cyc[2], d[0 +: 13], d[6*13 +: 13]);
      end
    end
    dc = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    checks++;
    if (done_cyc.size() != 1 || dc != 171) begin
      errors++;
      $display("FAIL empty_done got n=%0d cyc=%0d want n=1 cyc=171", done_cyc.size(), dc);
    end
    settle();
  endtask

  task automatic test_saturation();
    logic [90:0] d;
    fill(0, 22'h3FFFFF, 10'd1, 13'd5);
    fill(1, 22'h3FFFFF, 10'd1023, 13'd5);
    fill(2, 22'h3FFFFF, 10'd511, 13'd5);
    fill(3, 22'h3FFFFF, 10'd512, 13'd5);
    fill(4, 22'd24573, 10'd3, 13'd5);
    fill(5, 22'd16384, 10'd2, 13'd5);
    fill(6, 22'd0, 10'd5, 13'd5);
    fill(7, 22'h3FFFFF, 10'd1023, 13'd5);
    run_capture(230, -1, -1, -1, -1);
    checks++;
    if (st_dat.size() != 8) begin
      errors++;
      $display("FAIL sat_strobe_count got %0d want 8", st_dat.size());
    end
    for (int i = 0; i < 8 && i < st_dat.size(); i++) begin
      checks++;
      if (st_dat[i] !== exp_cent(i)) begin
        errors++;
        $display("FAIL sat_data_%0d got %h want %h", i, st_dat[i], exp_cent(i));
      end
    end
    if (st_dat.size() >= 6) begin
      for (int k = 0; k < 7; k++) begin
        d = st_dat[0];
        checks++;
        if (d[k*13 +: 13] !== 13'd8191) begin
          errors++;
          $display("FAIL sat_max_coord%0d got %0d want 8191", k, d[k*13 +: 13]);
        end
        d = st_dat[1];
        checks++;
        if (d[k*13 +: 13] !== 13'd4100) begin
          errors++;
          $display("FAIL sat_1023_coord%0d got %0d want 4100", k, d[k*13 +: 13]);
        end
      end
      d = st_dat[5];
      checks++;
      if (d[0 +: 13] !== 13'd8191) begin
        errors++;
        $display("FAIL sat_8192 got %0d want 8191", d[0 +: 13]);
      end
    end
    settle();
  endtask

  task automatic test_start_while_busy();
    int dc;
    load_base();
    run_capture(260, 10, 100, 193, -1);
    checks++;
    if (st_cyc.size() != 8) begin
      errors++;
      $display("FAIL busy_start_strobes got %0d want 8", st_cyc.size());
    end
    dc = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    checks++;
    if (done_cyc.size() != 1 || dc != 193) begin
      errors++;
      $display("FAIL busy_start_done got n=%0d cyc=%0d want n=1 cyc=193", done_cyc.size(), dc);
    end
    checks++;
    if (busy_fall != 194 || busy !== 1'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL busy_start_idle got fall=%0d busy=%0b state=%0d want 194/0/0",
               busy_fall, busy, dbg_state);
    end
    settle();
  endtask

  task automatic test_back_to_back();
    int d0, d1;
    load_base();
    run_capture(400, 194, -1, -1, -1);
    checks++;
    if (st_cyc.size() != 16) begin
      errors++;
      $display("FAIL b2b_strobes got %0d want 16", st_cyc.size());
    end
    for (int i = 0; i < 16 && i < st_cyc.size(); i++) begin
      checks++;
      if (st_cyc[i] != ((i < 8) ? 24 + 24 * i : 218 + 24 * (i - 8)) ||
          st_dat[i] !== exp_cent(i % 8)) begin
        errors++;
        $display("FAIL b2b_strobe_%0d got cyc=%0d dat=%h want cyc=%0d dat=%h", i, st_cyc[i],
                 st_dat[i], (i < 8) ? 24 + 24 * i : 218 + 24 * (i - 8), exp_cent(i % 8));
      end
    end
    d0 = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    d1 = (done_cyc.size() > 1) ? done_cyc[1] : -1;
    checks++;
    if (done_cyc.size() != 2 || d0 != 193 || d1 != 387) begin
      errors++;
      $display("FAIL b2b_done got n=%0d %0d %0d want 2 193 387", done_cyc.size(), d0, d1);
    end
    settle();
  endtask

  task automatic test_reset_mid_run();
    int dc;
    load_base();
    run_capture(120, -1, -1, -1, 60);
    checks++;
    if (snap !== 97'd0) begin
      errors++;
      $display("FAIL midrst_outputs got %h want 0", snap);
    end
    checks++;
    if (st_cyc.size() != 2 || done_cyc.size() != 0) begin
      errors++;
      $display("FAIL midrst_activity got strobes=%0d dones=%0d want 2 0",
               st_cyc.size(), done_cyc.size());
    end
    checks++;
    if (dbg_state !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle got state=%0d busy=%0b want 0 0", dbg_state, busy);
    end
    settle();
    run_capture(230, -1, -1, -1, -1);
    checks++;
    if (st_cyc.size() != 8) begin
      errors++;
      $display("FAIL midrst_rerun_strobes got %0d want 8", st_cyc.size());
    end
    for (int i = 0; i < 8 && i < st_cyc.size(); i++) begin
      checks++;
      if (st_cyc[i] != 24 + 24 * i || st_dat[i] !== exp_cent(i)) begin
        errors++;
        $display("FAIL midrst_rerun_%0d got cyc=%0d dat=%h want cyc=%0d dat=%h",
                 i, st_cyc[i], st_dat[i], 24 + 24 * i, exp_cent(i));
      end
    end
    dc = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    checks++;
    if (done_cyc.size() != 1 || dc != 193) begin
      errors++;
      $display("FAIL midrst_rerun_done got n=%0d cyc=%0d want 1 193", done_cyc.size(), dc);
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_exact_division();
    test_empty_cluster();
    test_saturation();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/new_means_calc.md
# new_means_calc

Computes the updated k-means centroids at the end of each iteration. It sits opposite the classification block on the accumulator/centroid interface. It consumes the eight per-centroid coordinate sums and point counts, divides each sum by its count, and streams the eight results back one per write strobe as `new_centroid` / `cent_cnt`.

## Interface
- `centroid_num`, 8: number of centroids; `cent_cnt` is 3 bits.
- `cordinate_width`, 13: bits per coordinate, unsigned.
- `accum_cord_width`, 22: bits per accumulated coordinate, unsigned.
- `count_width`, 10: bits per point count, unsigned.
- `dataWidth`, 91: 7 × `cordinate_width`; coordinate k occupies `[k*13 +: 13]`.
- `accum_width`, 154: 7 × `accum_cord_width`; sum k occupies `[k*22 +: 22]`.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  controller request; sampled only in IDLE.
- `accum_1..accum_8`  in  `accum_width`  per-centroid coordinate sums; must hold stable from `start` until `done`.
- `cnt_1..cnt_8`  in  `count_width`  per-centroid point counts; same stability rule.
- `centroid_reg_1..centroid_reg_8`  in  `dataWidth`  current centroids, used when a count is 0.
- `busy`  out  1  high from LOAD through DONE.
- `new_centroid_valid`  out  1  one-cycle write strobe.
- `cent_cnt`  out  3  index (0..7) of the centroid being written.
- `new_centroid`  out  `dataWidth`  packed new centroid.
- `done`  out  1  one-cycle pulse after the last write.

## Operation
- FSM states are IDLE, LOAD, DIV, WRITE and DONE. A 3-bit register `idx` holds the current centroid index.
- **IDLE:** when `start`=1, set `idx`=0 and go to LOAD. `start` is ignored in every other state.
- **LOAD:** latch the 7 sums and the count selected by `idx` (`accum_(idx+1)`, `cnt_(idx+1)`).
  - Count ≠ 0: go to DIV.
  - Count = 0: latch `centroid_reg_(idx+1)` as the result and go straight to WRITE.
- **DIV:**
  - Seven unsigned restoring dividers run in parallel, each 22-bit dividend by 10-bit divisor.
  - Each takes exactly 22 iterations, one quotient bit per cycle, MSB first. Then go to WRITE.
- **Quotient rule:**
  - The quotient is truncated toward zero; no rounding.
  - Quotients above 8191 saturate to 13'h1FFF per coordinate.
- **WRITE:**
  - `new_centroid_valid`=1, `cent_cnt`=`idx`, `new_centroid`=result.
  - If `idx`=7, go to DONE; otherwise increment `idx` and go to LOAD.
- **DONE:** `done`=1, then go to IDLE.
- **Output holding:** `new_centroid` and `cent_cnt` hold their last values between strobes. Consumers qualify them only with `new_centroid_valid`.
- **Reset, including mid-operation:**
  - FSM returns to IDLE and `idx`=0.
  - All outputs go to 0: `busy`, `new_centroid_valid`, `done`, `cent_cnt`, `new_centroid`.
  - Divider state is cleared, and no partial write is emitted.

## Timing
- Cycle 0 is the edge at which `start` is sampled in IDLE.
- Centroid with non-zero count: LOAD (1 cycle) + DIV (22) + WRITE (1) = 24 cycles.
- Centroid with zero count: LOAD + WRITE = 2 cycles.
- When all counts are non-zero:
  - Centroid i's strobe is in cycle 24 + 24·i.
  - `done` is in cycle 193; `busy` falls in cycle 194.
- `start` is accepted again in the cycle after `done`. Asserting `start` in the same cycle as `done` has no effect.
- `new_centroid_valid` and `done` are never high in the same cycle.

## Structure
- A shared package holds:
  - constants `NUM_CENT`=8, `NUM_COORD`=7, `COORD_W`=13, `ACC_W`=22, `CNT_W`=10;
  - the FSM state enum type.
- Sub-module `seq_divider`: one 22/10 restoring divider with `load` and `busy` signals and a saturated 13-bit quotient. It is instantiated 7 times.
- The top level holds the FSM, `idx`, the input muxing and the output registers.

## Test plan
- **Reset values:** assert `rst` for 2 cycles. All outputs are 0 and the FSM is in IDLE; with `start`=0 the FSM stays in IDLE for 50 cycles.
- **Exact division:** centroid 1 sums all 1000, `cnt_1`=3. The `cent_cnt`=0 strobe arrives at cycle 24 with every coordinate = 333. Centroid 2 sums all 44, `cnt_2`=4, gives 11 at cycle 48.
- **Empty cluster:** `cnt_3`=0 and `centroid_reg_3`=all coordinates 77. The `cent_cnt`=2 strobe is 2 cycles after its LOAD and carries 77, and the total run is 22 cycles shorter than in the all-non-zero case.
- **Saturation:** sums = 22'h3FFFFF, count 1. Every coordinate = 8191. With count 1023 the coordinate = 4100.
- **Start while busy:** pulse `start` at cycles 10 and 100. Exactly 8 strobes and 1 `done` occur, at cycle 193.
- **Reset mid-run:** assert `rst` at cycle 60, during the DIV of centroid 2. The next cycle has all outputs 0 and no further strobes. A fresh `start` then completes a normal 193-cycle run.
